uart_rx_gen2: RTL

UART_RX_GEN2 -- requirements
Module: uart_rx_gen2

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_rx_oversampler.sv | 41 ++++
 rtl/uart_rx_gen2.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8       = 6'd8;
  localparam logic [5:0] PRESCALE_16      = 6'd16;
  localparam logic [5:0] PRESCALE_32      = 6'd32;
  localparam logic [5:0] PRESCALE_DEFAULT = PRESCALE_16;

  // Frame settings captured at the start edge and held for the whole frame.
  typedef struct packed {
    logic [5:0] prescale;
    logic       par_en;
    logic       par_odd;
    logic       two_stop;
  } rx_cfg_t;

  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
      default:                              return PRESCALE_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_oversampler.sv
// Per-bit edge counter and 2-of-3 majority voter around the bit centre.
module uart_rx_oversampler
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] prescale,
  input  logic       line,
  output logic       bit_val,
  output logic       bit_rdy,
  output logic       bit_end
);

  logic [5:0] cnt_q;
  logic [5:0] half;
  logic       s0_q, s1_q;

  assign half    = prescale >> 1;
  assign bit_end = run && (cnt_q == prescale - 6'd1);
  assign bit_rdy = run && (cnt_q == half + 6'd1);
  // Third sample is the live line, so the vote resolves at half+1.
  assign bit_val = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);

  always_ff @(posedge clk) begin
    if (rst || !run)  cnt_q <= '0;
    else if (bit_end) cnt_q <= '0;
    else              cnt_q <= cnt_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      if (cnt_q == half - 6'd1) s0_q <= line;
      if (cnt_q == half)        s1_q <= line;
    end
  end

endmodule

// File: rtl/uart_rx_gen2.sv
// UART receiver: synchroniser, frame FSM, shift register, parity and stop checks.
module uart_rx_gen2
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Serial_Data,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  input  logic                  Stop_Bits,
  input  logic [5:0]            Prescale,
  output logic                  Data_Valid,
  output logic [DATA_WIDTH-1:0] Parallel_Data,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam int IDXW = $clog2(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line;
  rx_state_e              state_q, state_d;
  rx_cfg_t                cfg_q;
  logic                   run, bit_val, bit_rdy, bit_end;
  logic [IDXW-1:0]        bit_idx_q;
  logic                   stop_idx_q;
  logic [DATA_WIDTH-1:0]  sr_q;
  logic                   par_err_q, frm_err_q;
  logic                   done_go, stop_bad, dv_d, pe_d, se_d;

  always_ff @(posedge CLK) begin
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], Serial_Data};
  end
  assign line = sync_q[SYNC_STAGES-1];

  assign run = (state_q == START) || (state_q == DATA) ||
               (state_q == PARITY) || (state_q == STOP);

  uart_rx_oversampler u_os (
    .clk      (CLK),
    .rst      (RST),
    .run      (run),
    .prescale (cfg_q.prescale),
    .line     (line),
    .bit_val  (bit_val),
    .bit_rdy  (bit_rdy),
    .bit_end  (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!line) state_d = START;
      START:  if (bit_rdy && bit_val) state_d = IDLE;
              else if (bit_end)       state_d = DATA;
      DATA:   if (bit_end && bit_idx_q == IDXW'(DATA_WIDTH-1))
                state_d = cfg_q.par_en ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      // Leave at the vote of the last stop bit so the next start edge is seen.
      STOP:   if (bit_rdy && stop_idx_q == cfg_q.two_stop) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_go  = (state_q == STOP) && (state_d == DONE);
    stop_bad = frm_err_q | ~bit_val;
    dv_d     = done_go & ~par_err_q & ~stop_bad;
    pe_d     = done_go & par_err_q;
    se_d     = done_go & stop_bad;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_q      <= '{prescale: PRESCALE_DEFAULT, par_en: 1'b0, par_odd: 1'b0, two_stop: 1'b0};
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      sr_q       <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && !line) begin
        cfg_q      <= '{prescale: legal_prescale(Prescale), par_en: Parity_Enable,
                        par_odd: Parity_Type, two_stop: Stop_Bits};
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
        par_err_q  <= 1'b0;
        frm_err_q  <= 1'b0;
      end
      if (state_q == DATA && bit_rdy) sr_q <= {bit_val, sr_q[DATA_WIDTH-1:1]};
      if (state_q == DATA && bit_end) bit_idx_q <= bit_idx_q + IDXW'(1);
      if (state_q == PARITY && bit_rdy && (bit_val != (^sr_q ^ cfg_q.par_odd)))
        par_err_q <= 1'b1;
      if (state_q == STOP && bit_rdy && !bit_val) frm_err_q <= 1'b1;
      if (state_q == STOP && bit_end) stop_idx_q <= 1'b1;
    end
  end

  // Outputs register on entry to DONE so they are valid during the DONE cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Data_Valid    <= 1'b0;
      Parity_Error  <= 1'b0;
      Stop_Error    <= 1'b0;
      Parallel_Data <= '0;
    end else begin
      Data_Valid   <= dv_d;
      Parity_Error <= pe_d;
      Stop_Error   <= se_d;
      if (dv_d) Parallel_Data <= sr_q;
    end
  end

endmodule
